// File: rtl/sseg_if.sv
// Seven-segment display bus as seen by a snooping decoder: raw anode/segment lines in,
// recovered digit values and status out.
interface sseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    update;
    logic                    err_bad_pattern;
    logic                    stale;

    modport master (
        output an_n, seg, err_clr,
        input  digits, digit_valid, update, err_bad_pattern, stale
    );

    modport slave (
        input  an_n, seg, err_clr,
        output digits, digit_valid, update, err_bad_pattern, stale
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus.
// Optional watchdog enabled by defining SSEG_RX_TIMEOUT_EN.
module sseg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 16,
    parameter int MATCH_COUNT    = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic   clk,
    input logic   rst,
    sseg_if.slave bus
);
    localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int MW = $clog2(MATCH_COUNT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] CLS_HEX   = 2'd0;
    localparam logic [1:0] CLS_BLANK = 2'd1;
    localparam logic [1:0] CLS_BAD   = 2'd2;

    if (SETTLE_CYCLES < 2) begin : g_chk_settle
        $error("SETTLE_CYCLES must be >= 2");
    end
    if (MATCH_COUNT < 1) begin : g_chk_match
        $error("MATCH_COUNT must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    // Sample class in [5:4], hex value in [3:0] (zero for blank/bad so whole-word compare works).
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = {CLS_HEX, 4'h0};
            7'h79: decode = {CLS_HEX, 4'h1};
            7'h24: decode = {CLS_HEX, 4'h2};
            7'h30: decode = {CLS_HEX, 4'h3};
            7'h19: decode = {CLS_HEX, 4'h4};
            7'h12: decode = {CLS_HEX, 4'h5};
            7'h02: decode = {CLS_HEX, 4'h6};
            7'h78: decode = {CLS_HEX, 4'h7};
            7'h00: decode = {CLS_HEX, 4'h8};
            7'h18: decode = {CLS_HEX, 4'h9};
            7'h08: decode = {CLS_HEX, 4'hA};
            7'h03: decode = {CLS_HEX, 4'hB};
            7'h46: decode = {CLS_HEX, 4'hC};
            7'h21: decode = {CLS_HEX, 4'hD};
            7'h06: decode = {CLS_HEX, 4'hE};
            7'h0E: decode = {CLS_HEX, 4'hF};
            7'h7F: decode = {CLS_BLANK, 4'h0};
            default: decode = {CLS_BAD, 4'h0};
        endcase
    endfunction

    logic [NUM_DIGITS-1:0]           an_meta_q, an_sync_q;
    logic [6:0]                      seg_meta_q, seg_sync_q;
    logic [1:0]                      state_q, state_d;
    logic [NUM_DIGITS-1:0]           an_lat_q, an_lat_d;
    logic [KW-1:0]                   idx_q, idx_d;
    logic [SW-1:0]                   settle_q, settle_d;
    logic [NUM_DIGITS-1:0][5:0]      cand_q, cand_d;
    logic [NUM_DIGITS-1:0][MW-1:0]   match_q, match_d;
    logic                            pend_q, pend_d;
    logic [KW-1:0]                   pend_idx_q, pend_idx_d;
    logic [5:0]                      pend_cand_q, pend_cand_d;
    logic [4*NUM_DIGITS-1:0]         digits_q, digits_d;
    logic [NUM_DIGITS-1:0]           valid_q, valid_d;
    logic                            update_q, update_d;
    logic                            err_q, err_d;

    logic [NUM_DIGITS-1:0] an_low;
    logic                  one_low;
    logic [KW-1:0]         low_idx;
    logic                  an_changed;
    logic                  sample_en;
    logic [5:0]            samp;
    logic                  hit;
    logic [MW-1:0]         old_cnt, new_cnt;

`ifdef SSEG_RX_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           stale_q, stale_d;
`endif

    assign an_low     = ~an_sync_q;
    assign one_low    = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign an_changed = (an_sync_q != an_lat_q);
    assign sample_en  = (state_q == ST_SETTLE) && !an_changed &&
                        (settle_q == SW'(SETTLE_CYCLES - 1));
    assign samp       = decode(seg_sync_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        low_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync_q[i]) low_idx = KW'(i);
        end
    end

    // Scan FSM: one sample per anode visit, taken once the lines have been stable long enough.
    always_comb begin
        state_d  = state_q;
        an_lat_d = an_lat_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (one_low) begin
                    an_lat_d = an_sync_q;
                    idx_d    = low_idx;
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (an_changed)     state_d  = ST_IDLE;
                else if (sample_en) state_d  = ST_DONE;
                else                settle_d = settle_q + SW'(1);
            end
            ST_DONE: begin
                if (an_changed) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cand_d      = cand_q;
        match_d     = match_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_cand_d = pend_cand_q;
        digits_d    = digits_q;
        valid_d     = valid_q;
        err_d       = err_q;
        hit         = (samp == cand_q[idx_q]);
        old_cnt     = match_q[idx_q];
        new_cnt     = MW'(1);
        if (hit) new_cnt = (old_cnt == MW'(MATCH_COUNT)) ? old_cnt : old_cnt + MW'(1);

        if (sample_en) begin
            cand_d[idx_q]  = samp;
            match_d[idx_q] = new_cnt;
            // Commit only on the transition into MATCH_COUNT, never while saturated.
            if (new_cnt == MW'(MATCH_COUNT) && (!hit || old_cnt != MW'(MATCH_COUNT))) begin
                pend_d      = 1'b1;
                pend_idx_d  = idx_q;
                pend_cand_d = samp;
            end
        end

        if (bus.err_clr) err_d = 1'b0;
        if (pend_q) begin
            if (pend_cand_q[5:4] == CLS_HEX) begin
                digits_d[4*pend_idx_q +: 4] = pend_cand_q[3:0];
                valid_d[pend_idx_q]         = 1'b1;
            end else begin
                valid_d[pend_idx_q] = 1'b0;
                if (pend_cand_q[5:4] == CLS_BAD) err_d = 1'b1;
            end
        end

`ifdef SSEG_RX_TIMEOUT_EN
        wd_d    = wd_q;
        stale_d = stale_q;
        if (sample_en) begin
            wd_d    = '0;
            stale_d = 1'b0;
        end else if (!stale_q) begin
            if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                stale_d = 1'b1;
                valid_d = '0;
                // Restart match counting so a digit still on the panel recommits once scanning resumes.
                match_d = '0;
            end else begin
                wd_d = wd_q + WDW'(1);
            end
        end
`endif

        update_d = (digits_d != digits_q) || (valid_d != valid_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_meta_q   <= '1;
            an_sync_q   <= '1;
            seg_meta_q  <= 7'h7F;
            seg_sync_q  <= 7'h7F;
            state_q     <= ST_IDLE;
            an_lat_q    <= '1;
            idx_q       <= '0;
            settle_q    <= '0;
            // NOTE: the per-digit candidate arrays are small register banks, not RAM, so they are reset.
            cand_q      <= '0;
            match_q     <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_cand_q <= '0;
            digits_q    <= '0;
            valid_q     <= '0;
            update_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            an_meta_q   <= bus.an_n;
            an_sync_q   <= an_meta_q;
            seg_meta_q  <= bus.seg;
            seg_sync_q  <= seg_meta_q;
            state_q     <= state_d;
            an_lat_q    <= an_lat_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            cand_q      <= cand_d;
            match_q     <= match_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_cand_q <= pend_cand_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            update_q    <= update_d;
            err_q       <= err_d;
        end
    end

`ifdef SSEG_RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            stale_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            stale_q <= stale_d;
        end
    end
    assign bus.stale = stale_q;
`else
    assign bus.stale = 1'b0;
`endif

    assign bus.digits          = digits_q;
    assign bus.digit_valid     = valid_q;
    assign bus.update          = update_q;
    assign bus.err_bad_pattern = err_q;
endmodule
